// File: rtl/axil_reg_pkg.sv
// rtl/axil_reg_pkg.sv - shared register offsets, response codes and helpers
package axil_reg_pkg;

  localparam int unsigned ADDR_W = 15;

  localparam logic [ADDR_W-1:0] OFF_ID      = 15'h00;
  localparam logic [ADDR_W-1:0] OFF_SCRATCH = 15'h04;
  localparam logic [ADDR_W-1:0] OFF_CTRL    = 15'h08;
  localparam logic [ADDR_W-1:0] OFF_STATUS  = 15'h0C;
  localparam logic [ADDR_W-1:0] OFF_EVENT   = 15'h10;
  localparam logic [ADDR_W-1:0] OFF_CYCLES  = 15'h14;
  localparam logic [ADDR_W-1:0] OFF_WRCOUNT = 15'h18;
  localparam logic [ADDR_W-1:0] OFF_LAST    = OFF_WRCOUNT;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_C0DE;
  localparam logic [31:0] ID_DEFAULT  = 32'h5A17_0001;

  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  // Word-aligned and inside the implemented map
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00) && (addr <= OFF_LAST);
  endfunction

  // Byte-wise merge of new data into an existing register value
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_reg_bank_if.sv
// rtl/axil_reg_bank_if.sv - AXI-Lite style register bus bundle
interface axil_reg_bank_if;
  import axil_reg_pkg::*;

  logic [ADDR_W-1:0] axi_awaddr;
  logic              axi_awvalid;
  logic              axi_awready;
  logic [31:0]       axi_wdata;
  logic [3:0]        axi_wstrb;
  logic              axi_wvalid;
  logic              axi_wready;
  logic [1:0]        axi_bresp;
  logic              axi_bvalid;
  logic              axi_bready;
  logic [ADDR_W-1:0] axi_araddr;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [31:0]       axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rvalid;
  logic              axi_rready;

  modport master (
    output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
           axi_araddr, axi_arvalid, axi_rready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready,
           axi_rdata, axi_rresp, axi_rvalid
  );

  modport slave (
    input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
           axi_araddr, axi_arvalid, axi_rready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready,
           axi_rdata, axi_rresp, axi_rvalid
  );

endinterface

// File: rtl/axil_event_latch.sv
// rtl/axil_event_latch.sv - sticky event bits with byte-strobed write-one-to-clear
module axil_event_latch #(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [W-1:0]       evt_set,
  input  logic [W-1:0]       evt_clr,
  input  logic               clr_en,
  input  logic [(W+7)/8-1:0] strb,
  output logic [W-1:0]       q
);

  logic [W-1:0] clr_mask;

  // Expand byte strobes onto the individual clear bits
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < W; i++) begin
      clr_mask[i] = clr_en & evt_clr[i] & strb[i/8];
    end
  end

  // Sticky bits: a new event in the same cycle wins over a clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q <= '0;
    else       q <= (q & ~clr_mask) | evt_set;
  end

endmodule

// File: rtl/axil_reg_bank.sv
// rtl/axil_reg_bank.sv - AXI-Lite register bank with ID, scratch, control, status, events and counters
module axil_reg_bank
  import axil_reg_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = ID_DEFAULT,
  parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rstn,
  axil_reg_bank_if.slave        axi,
  output logic [31:0]           ctrl_out,
  input  logic [15:0]           status_in,
  input  logic [7:0]            event_in
);

  logic [31:0] scratch;
  logic [31:0] ctrl;
  logic [31:0] cycles;
  logic [31:0] wrcount;
  logic [7:0]  event_q;
  logic        wr_accept;
  logic        wr_ok;
  logic        evt_clr_en;
  logic        rd_accept;
  logic        rd_ok;
  logic [31:0] rd_value;
  rd_state_t   state, state_next;

  // Address and data are taken together; the pending response blocks a repeat accept
  assign wr_accept       = rstn && axi.axi_awvalid && axi.axi_wvalid && !axi.axi_bvalid;
  assign axi.axi_awready = wr_accept;
  assign axi.axi_wready  = wr_accept;
  assign wr_ok           = addr_ok(axi.axi_awaddr);
  assign evt_clr_en      = wr_accept && wr_ok && (axi.axi_awaddr == OFF_EVENT);
  assign ctrl_out        = ctrl;
  assign axi.axi_rvalid  = (state == R_RESP);

  // Write response: raised after each accepted write, held until bready
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      axi.axi_bvalid <= 1'b0;
      axi.axi_bresp  <= RESP_OKAY;
    end else if (wr_accept) begin
      axi.axi_bvalid <= 1'b1;
      axi.axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (axi.axi_bready) begin
      axi.axi_bvalid <= 1'b0;
    end
  end

  // RW registers merge by byte strobe; error writes leave them untouched
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scratch <= '0;
      ctrl    <= CTRL_RST;
    end else if (wr_accept && wr_ok) begin
      case (axi.axi_awaddr)
        OFF_SCRATCH: scratch <= apply_strb(scratch, axi.axi_wdata, axi.axi_wstrb);
        OFF_CTRL:    ctrl    <= apply_strb(ctrl, axi.axi_wdata, axi.axi_wstrb);
        default:     ;
      endcase
    end
  end

  // Free-running cycle counter and count of every accepted write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycles  <= '0;
      wrcount <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (wr_accept) wrcount <= wrcount + 32'd1;
    end
  end

  axil_event_latch #(.W(8)) u_event (
    .clk     (clk),
    .rstn    (rstn),
    .evt_set (event_in),
    .evt_clr (axi.axi_wdata[7:0]),
    .clr_en  (evt_clr_en),
    .strb    (axi.axi_wstrb[0:0]),
    .q       (event_q)
  );

  // Read mux over the register map; holes and misaligned addresses give the error pattern
  always_comb begin
    rd_ok    = addr_ok(axi.axi_araddr);
    rd_value = ERR_PATTERN;
    case (axi.axi_araddr)
      OFF_ID:      rd_value = ID_VALUE;
      OFF_SCRATCH: rd_value = scratch;
      OFF_CTRL:    rd_value = ctrl;
      OFF_STATUS:  rd_value = {16'h0000, status_in};
      OFF_EVENT:   rd_value = {24'h00_0000, event_q};
      OFF_CYCLES:  rd_value = cycles;
      OFF_WRCOUNT: rd_value = wrcount;
      default:     rd_value = ERR_PATTERN;
    endcase
  end

  // Read FSM next state and address-ready
  always_comb begin
    state_next      = state;
    axi.axi_arready = 1'b0;
    rd_accept       = 1'b0;
    case (state)
      R_IDLE: begin
        axi.axi_arready = rstn;
        rd_accept       = rstn && axi.axi_arvalid;
        if (rd_accept) state_next = R_RESP;
      end
      R_RESP: begin
        if (axi.axi_rready) state_next = R_IDLE;
      end
      default: state_next = R_IDLE;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= R_IDLE;
    else       state <= state_next;
  end

  // Capture the read response at acceptance; it holds until rready
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      axi.axi_rdata <= '0;
      axi.axi_rresp <= RESP_OKAY;
    end else if (rd_accept) begin
      axi.axi_rdata <= rd_value;
      axi.axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
// tb/tb_axil_reg_bank.sv - scoreboard bench for axil_reg_bank
module tb_axil_reg_bank;
  import axil_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] status_in = 16'hBEEF;
  logic [7:0]  event_in = 8'h00;
  logic [31:0] ctrl_out;

  int errors = 0;
  int checks = 0;
  int aw_hs = 0;
  int wr_model = 0;
  logic [31:0] ctrl_at_accept;

  logic [1:0]  exp_b[$];
  logic [48:0] exp_r[$];

  axil_reg_bank_if bus();

  axil_reg_bank #(.ID_VALUE(ID_DEFAULT), .CTRL_RST(32'h0000_0000)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .axi       (bus),
    .ctrl_out  (ctrl_out),
    .status_in (status_in),
    .event_in  (event_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitors: pop the scoreboard on every completing handshake
  initial begin
    logic [1:0]  eb;
    logic [48:0] er;
    forever begin
      @(negedge clk);
      if (bus.axi_awvalid && bus.axi_awready) aw_hs++;
      if (rstn && bus.axi_bvalid && bus.axi_bready) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bresp: got resp %0d, expected no response", bus.axi_bresp);
        end else begin
          eb = exp_b.pop_front();
          check("bresp", {30'b0, bus.axi_bresp}, {30'b0, eb});
        end
      end
      if (rstn && bus.axi_rvalid && bus.axi_rready) begin
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rresp: got rdata %h, expected no response", bus.axi_rdata);
        end else begin
          er = exp_r.pop_front();
          check($sformatf("rdata@%h", er[48:34]), bus.axi_rdata, er[31:0]);
          check($sformatf("rresp@%h", er[48:34]), {30'b0, bus.axi_rresp}, {30'b0, er[33:32]});
        end
      end
    end
  end

  task automatic drain_b();
    for (int i = 0; i < 20 && exp_b.size() != 0; i++) tick();
    if (exp_b.size() != 0) begin
      checks++; errors++;
      $display("FAIL bresp_timeout: got no response, expected %0d pending", exp_b.size());
      exp_b.delete();
    end
  endtask

  task automatic drain_r();
    for (int i = 0; i < 20 && exp_r.size() != 0; i++) tick();
    if (exp_r.size() != 0) begin
      checks++; errors++;
      $display("FAIL rresp_timeout: got no response, expected %0d pending", exp_r.size());
      exp_r.delete();
    end
  endtask

  task automatic wr(input logic [14:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [1:0] resp, input bit hold);
    bit got = 1'b0;
    exp_b.push_back(resp);
    bus.axi_awaddr = addr; bus.axi_wdata = data; bus.axi_wstrb = strb;
    bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.axi_awready;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL aw_timeout: got awready 0, expected 1 at %h", addr);
    end else begin
      wr_model++;
    end
    tick();
    ctrl_at_accept = ctrl_out;
    event_in = 8'h00;
    if (hold) tick();
    bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
    drain_b();
  endtask

  task automatic rd(input logic [14:0] addr, input logic [31:0] data, input logic [1:0] resp,
                    input int stall);
    bit got = 1'b0;
    exp_r.push_back({addr, resp, data});
    if (stall > 0) bus.axi_rready = 1'b0;
    bus.axi_araddr = addr; bus.axi_arvalid = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.axi_arready;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ar_timeout: got arready 0, expected 1 at %h", addr);
    end
    tick();
    bus.axi_arvalid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_rvalid", {31'b0, bus.axi_rvalid}, 32'd1);
      check("stall_rdata", bus.axi_rdata, data);
      check("stall_arready", {31'b0, bus.axi_arready}, 32'd0);
    end
    if (stall > 0) begin
      tick();
      bus.axi_rready = 1'b1;
    end
    drain_r();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    int aw0;
    bus.axi_awaddr = '0; bus.axi_awvalid = 1'b1; bus.axi_wdata = '1; bus.axi_wstrb = 4'hF;
    bus.axi_wvalid = 1'b1; bus.axi_bready = 1'b1;
    bus.axi_araddr = '0; bus.axi_arvalid = 1'b1; bus.axi_rready = 1'b1;
    #12;
    check("reset_awready", {31'b0, bus.axi_awready}, 32'd0);
    check("reset_wready",  {31'b0, bus.axi_wready},  32'd0);
    check("reset_arready", {31'b0, bus.axi_arready}, 32'd0);
    check("reset_valids",  {30'b0, bus.axi_bvalid, bus.axi_rvalid}, 32'd0);
    check("reset_resps",   {28'b0, bus.axi_bresp, bus.axi_rresp}, 32'd0);
    check("reset_rdata",   bus.axi_rdata, 32'd0);
    check("reset_ctrl_out", ctrl_out, 32'd0);
    bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0; bus.axi_arvalid = 1'b0;
    #10 rstn = 1'b1;
    tick();

    rd(OFF_ID, 32'h5A17_0001, RESP_OKAY, 0);

    aw0 = aw_hs;
    wr(OFF_SCRATCH, 32'h1234_5678, 4'hF, RESP_OKAY, 1'b1);
    check("single_accept", aw_hs - aw0, 32'd1);
    rd(OFF_SCRATCH, 32'h1234_5678, RESP_OKAY, 0);
    rd(OFF_WRCOUNT, 32'd1, RESP_OKAY, 0);

    wr(OFF_CTRL, 32'hFFFF_FFFF, 4'h2, RESP_OKAY, 1'b0);
    check("ctrl_out_after_accept", ctrl_at_accept, 32'h0000_FF00);
    rd(OFF_CTRL, 32'h0000_FF00, RESP_OKAY, 0);

    wr(OFF_SCRATCH, 32'hAABB_CCDD, 4'b0101, RESP_OKAY, 1'b0);
    rd(OFF_SCRATCH, 32'h12BB_56DD, RESP_OKAY, 0);

    rd(OFF_STATUS, 32'h0000_BEEF, RESP_OKAY, 0);
    wr(OFF_STATUS, 32'hFFFF_FFFF, 4'hF, RESP_OKAY, 1'b0);
    wr(OFF_ID, 32'h0000_0000, 4'hF, RESP_OKAY, 1'b0);
    rd(OFF_ID, 32'h5A17_0001, RESP_OKAY, 0);
    rd(OFF_STATUS, 32'h0000_BEEF, RESP_OKAY, 0);

    event_in = 8'h05; tick(); event_in = 8'h00;
    rd(OFF_EVENT, 32'h0000_0005, RESP_OKAY, 0);
    event_in = 8'h01;
    wr(OFF_EVENT, 32'h0000_0001, 4'hF, RESP_OKAY, 1'b0);
    rd(OFF_EVENT, 32'h0000_0005, RESP_OKAY, 0);
    wr(OFF_EVENT, 32'h0000_0005, 4'hF, RESP_OKAY, 1'b0);
    rd(OFF_EVENT, 32'h0000_0000, RESP_OKAY, 0);
    event_in = 8'h80; tick(); event_in = 8'h00;
    wr(OFF_EVENT, 32'h0000_00FF, 4'h0, RESP_OKAY, 1'b0);
    rd(OFF_EVENT, 32'h0000_0080, RESP_OKAY, 0);
    wr(OFF_EVENT, 32'h0000_00FF, 4'h1, RESP_OKAY, 1'b0);
    rd(OFF_EVENT, 32'h0000_0000, RESP_OKAY, 0);

    rd(15'h001C, 32'hDEAD_C0DE, RESP_SLVERR, 0);
    rd(15'h0002, 32'hDEAD_C0DE, RESP_SLVERR, 0);
    wr(15'h001C, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 1'b0);
    wr(15'h000A, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 1'b0);
    rd(OFF_SCRATCH, 32'h12BB_56DD, RESP_OKAY, 0);
    rd(OFF_CTRL, 32'h0000_FF00, RESP_OKAY, 0);
    rd(OFF_WRCOUNT, wr_model, RESP_OKAY, 0);

    fork
      rd(OFF_SCRATCH, 32'h12BB_56DD, RESP_OKAY, 0);
      wr(OFF_SCRATCH, 32'hCAFE_F00D, 4'hF, RESP_OKAY, 1'b0);
    join
    rd(OFF_SCRATCH, 32'hCAFE_F00D, RESP_OKAY, 0);

    rd(OFF_SCRATCH, 32'hCAFE_F00D, RESP_OKAY, 5);

    @(negedge clk);
    force dut.cycles = 32'hFFFF_FFFE;
    #1;
    release dut.cycles;
    tick();
    rd(OFF_CYCLES, 32'hFFFF_FFFF, RESP_OKAY, 0);
    rd(OFF_CYCLES, 32'h0000_0001, RESP_OKAY, 0);

    bus.axi_rready = 1'b0;
    bus.axi_araddr = OFF_ID; bus.axi_arvalid = 1'b1;
    @(negedge clk);
    check("midread_arready", {31'b0, bus.axi_arready}, 32'd1);
    tick();
    bus.axi_arvalid = 1'b0;
    @(negedge clk);
    check("midread_rvalid_before", {31'b0, bus.axi_rvalid}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("midread_rvalid_reset", {31'b0, bus.axi_rvalid}, 32'd0);
    check("midread_rdata_reset", bus.axi_rdata, 32'd0);
    check("midread_arready_reset", {31'b0, bus.axi_arready}, 32'd0);
    bus.axi_rready = 1'b1;
    tick(); tick();
    rstn = 1'b1;
    wr_model = 0;
    repeat (10) tick();
    check("post_reset_ctrl_out", ctrl_out, 32'd0);
    rd(OFF_SCRATCH, 32'd0, RESP_OKAY, 0);
    rd(OFF_WRCOUNT, wr_model, RESP_OKAY, 0);
    rd(OFF_EVENT, 32'd0, RESP_OKAY, 0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
